// File: rtl/difficulty_select_pkg.sv
// Shared difficulty encodings, used by the selector, the HEX4 display and the game-timing logic.
package difficulty_select_pkg;

    localparam int unsigned DIFF_W = 3;

    typedef logic [DIFF_W-1:0] diff_t;

    localparam diff_t DIFF_EASY   = 3'b001;
    localparam diff_t DIFF_MEDIUM = 3'b010;
    localparam diff_t DIFF_HARD   = 3'b100;

endpackage

// File: rtl/difficulty_select_if.sv
// Button, lock and difficulty signals between the board I/O and the difficulty selector.
interface difficulty_select_if;
    import difficulty_select_pkg::*;

    logic  key_up_n;
    logic  key_down_n;
    logic  lock;
    diff_t diff;
    logic  diff_changed;

    modport master (
        output key_up_n,
        output key_down_n,
        output lock,
        input  diff,
        input  diff_changed
    );

    modport slave (
        input  key_up_n,
        input  key_down_n,
        input  lock,
        output diff,
        output diff_changed
    );

endinterface

// File: rtl/key_debounce.sv
// Two-flop synchroniser, stability counter and single-cycle press pulse for one active-low button.
module key_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic press
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    logic             s;
    logic             db_q, db_d;
    logic             db_dly_q;
    logic             press_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign s = ~sync_q[1];

    always_comb begin
        db_d  = db_q;
        cnt_d = '0;
        if (s != db_q) begin
            if (cnt_q == CNT_MAX) begin
                db_d = s;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Synchroniser resets to released so a button held through reset is re-qualified from scratch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q   <= 2'b11;
            db_q     <= 1'b0;
            db_dly_q <= 1'b0;
            cnt_q    <= '0;
            press_q  <= 1'b0;
        end else begin
            sync_q   <= {sync_q[0], key_n};
            db_q     <= db_d;
            db_dly_q <= db_q;
            cnt_q    <= cnt_d;
            press_q  <= db_q & ~db_dly_q;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/difficulty_select.sv
// Difficulty selector: debounced up/down buttons step a saturating one-hot EASY/MEDIUM/HARD state.
module difficulty_select
    import difficulty_select_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input logic                clk,
    input logic                rst,
    difficulty_select_if.slave bus
);

    logic  up_press, down_press;
    logic  up_ok, down_ok;
    // Kept as a raw vector rather than an enum so corrupted codes stay representable and recoverable.
    diff_t diff_q, diff_d;
    logic  changed_q, changed_d;

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_up (
        .clk  (clk),
        .rst  (rst),
        .key_n(bus.key_up_n),
        .press(up_press)
    );

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_down (
        .clk  (clk),
        .rst  (rst),
        .key_n(bus.key_down_n),
        .press(down_press)
    );

    assign up_ok   = up_press & ~down_press & ~bus.lock;
    assign down_ok = down_press & ~up_press & ~bus.lock;

    always_comb begin
        diff_d = diff_q;
        unique case (diff_q)
            DIFF_EASY: begin
                if (up_ok) diff_d = DIFF_MEDIUM;
            end
            DIFF_MEDIUM: begin
                if (up_ok) begin
                    diff_d = DIFF_HARD;
                end else if (down_ok) begin
                    diff_d = DIFF_EASY;
                end
            end
            DIFF_HARD: begin
                if (down_ok) diff_d = DIFF_MEDIUM;
            end
            default: diff_d = DIFF_EASY;
        endcase
        changed_d = (diff_d != diff_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            diff_q    <= DIFF_EASY;
            changed_q <= 1'b0;
        end else begin
            diff_q    <= diff_d;
            changed_q <= changed_d;
        end
    end

    assign bus.diff         = diff_q;
    assign bus.diff_changed = changed_q;

endmodule

// File: tb/tb_difficulty_select.sv
// Directed bench for difficulty_select with a short debounce window.
module tb_difficulty_select;
    import difficulty_select_pkg::*;

    localparam int unsigned DC = 4;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   pulses = 0;

    difficulty_select_if bus();

    difficulty_select #(
        .DEBOUNCE_CYCLES(DC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk3(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chkn(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance n falling edges, tallying diff_changed pulses seen.
    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            if (bus.diff_changed === 1'b1) pulses++;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(2);
        chk3("rst_diff", bus.diff, DIFF_EASY);
        chk1("rst_chg", bus.diff_changed, 1'b0);
        rst = 1'b0;
        cyc(1);
    endtask

    task automatic press(input bit up);
        if (up) bus.key_up_n = 1'b0;
        else    bus.key_down_n = 1'b0;
        cyc(10);
        bus.key_up_n   = 1'b1;
        bus.key_down_n = 1'b1;
        cyc(10);
    endtask

    initial begin
        bus.key_up_n   = 1'b1;
        bus.key_down_n = 1'b1;
        bus.lock       = 1'b0;
        rst            = 1'b1;

        // Reset, then 50 idle cycles.
        cyc(2);
        chk3("init_diff", bus.diff, DIFF_EASY);
        chk1("init_chg", bus.diff_changed, 1'b0);
        rst    = 1'b0;
        pulses = 0;
        for (int i = 0; i < 50; i++) begin
            cyc(1);
            chk3("idle_diff", bus.diff, DIFF_EASY);
        end
        chkn("idle_pulses", pulses, 0);

        // Held press: first sampled at edge k, diff moves at edge k+DC+3.
        pulses       = 0;
        bus.key_up_n = 1'b0;
        cyc(DC + 3);
        chk3("hold_pre", bus.diff, DIFF_EASY);
        cyc(1);
        chk3("hold_diff", bus.diff, DIFF_MEDIUM);
        chk1("hold_chg", bus.diff_changed, 1'b1);
        cyc(1);
        chk1("hold_chg_low", bus.diff_changed, 1'b0);
        cyc(20);
        chk3("hold_stay", bus.diff, DIFF_MEDIUM);
        chkn("hold_pulses", pulses, 1);
        bus.key_up_n = 1'b1;
        cyc(10);

        // Up presses saturate at HARD, down presses saturate at EASY.
        do_reset();
        pulses = 0;
        press(1'b1); chk3("up1", bus.diff, DIFF_MEDIUM);
        press(1'b1); chk3("up2", bus.diff, DIFF_HARD);
        press(1'b1); chk3("up3", bus.diff, DIFF_HARD);
        press(1'b1); chk3("up4", bus.diff, DIFF_HARD);
        chkn("up_pulses", pulses, 2);
        pulses = 0;
        press(1'b0); chk3("dn1", bus.diff, DIFF_MEDIUM);
        press(1'b0); chk3("dn2", bus.diff, DIFF_EASY);
        press(1'b0); chk3("dn3", bus.diff, DIFF_EASY);
        press(1'b0); chk3("dn4", bus.diff, DIFF_EASY);
        chkn("dn_pulses", pulses, 2);

        // Chatter of DC-1 low cycles never qualifies.
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            bus.key_up_n = 1'b0;
            cyc(DC - 1);
            bus.key_up_n = 1'b1;
            cyc(1);
        end
        cyc(10);
        chk3("chatter_diff", bus.diff, DIFF_EASY);
        chkn("chatter_pulses", pulses, 0);

        // Exactly DC low cycles is just enough.
        bus.key_up_n = 1'b0;
        cyc(DC);
        bus.key_up_n = 1'b1;
        cyc(12);
        chk3("exact_diff", bus.diff, DIFF_MEDIUM);
        chkn("exact_pulses", pulses, 1);

        // Press during lock is dropped, and unlocking while held applies nothing.
        do_reset();
        pulses       = 0;
        bus.lock     = 1'b1;
        bus.key_up_n = 1'b0;
        cyc(10);
        bus.lock = 1'b0;
        cyc(10);
        bus.key_up_n = 1'b1;
        cyc(10);
        chk3("lock_diff", bus.diff, DIFF_EASY);
        chkn("lock_pulses", pulses, 0);
        press(1'b1);
        chk3("unlock_diff", bus.diff, DIFF_MEDIUM);
        chkn("unlock_pulses", pulses, 1);

        // Simultaneous up and down from MEDIUM: no change.
        pulses         = 0;
        bus.key_up_n   = 1'b0;
        bus.key_down_n = 1'b0;
        cyc(10);
        bus.key_up_n   = 1'b1;
        bus.key_down_n = 1'b1;
        cyc(10);
        chk3("both_diff", bus.diff, DIFF_MEDIUM);
        chkn("both_pulses", pulses, 0);

        // Corrupt the state register to a non-one-hot code.
        pulses = 0;
        force dut.diff_q = 3'b011;
        #1;
        release dut.diff_q;
        cyc(1);
        chk3("illegal_diff", bus.diff, DIFF_EASY);
        chk1("illegal_chg", bus.diff_changed, 1'b1);
        cyc(1);
        chk1("illegal_chg_low", bus.diff_changed, 1'b0);
        chkn("illegal_pulses", pulses, 1);

        // Asynchronous reset in the middle of a debounce window.
        press(1'b1);
        chk3("pre_arst", bus.diff, DIFF_MEDIUM);
        bus.key_up_n = 1'b0;
        cyc(3);
        #2;
        rst = 1'b1;
        #1;
        chk3("arst_diff", bus.diff, DIFF_EASY);
        chk1("arst_chg", bus.diff_changed, 1'b0);
        bus.key_up_n = 1'b1;
        cyc(3);
        pulses = 0;
        rst    = 1'b0;
        cyc(20);
        chk3("post_arst_diff", bus.diff, DIFF_EASY);
        chkn("post_arst_pulses", pulses, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/difficulty_select.md
Name: difficulty_select

Overview:
- Upstream of the HEX4 difficulty display. Owns the game's difficulty setting.
- Turns two raw, active-low push-buttons (up/down) into a registered one-hot difficulty code, diff[2:0]: 001 easy, 010 medium, 100 hard.
- Each button is synchronised and debounced, then edge-detected.
- Changes are frozen while the game is running (lock high). The display and game-timing logic consume diff directly.

Parameters:
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles required before a button level is accepted (10 ms at 50 MHz). Must be ≥ 2.
- CNT_W, $clog2(DEBOUNCE_CYCLES): width of each debounce counter.

Ports:
- clk  input  1  system clock (50 MHz).
- rst  input  1  asynchronous, active-high reset.
- key_up_n  input  1  raw button, low = pressed. Asynchronous to clk.
- key_down_n  input  1  raw button, low = pressed. Asynchronous to clk.
- lock  input  1  high while a game round runs; ignore presses.
- diff  output  3  registered one-hot difficulty.
- diff_changed  output  1  one-cycle pulse on the cycle diff takes a new value.

Behaviour:
- Reset (asynchronous, active-high). While rst is high:
  - diff = 3'b001; diff_changed = 0.
  - Both synchroniser flops hold 1 (released).
  - Debounced level = released; debounce counters = 0; press pulses = 0.
- Per-button path. The synchronised, inverted level is s (1 = pressed); the accepted level is db.
  - Two-flop synchroniser on each raw input.
  - s == db: counter ← 0.
  - s != db and counter < DEBOUNCE_CYCLES-1: counter ← counter + 1.
  - s != db and counter == DEBOUNCE_CYCLES-1: db ← s, counter ← 0.
  - press = registered 0→1 transition of db. It lasts exactly one cycle, and only one pulse is produced per physical press.
  - Glitches shorter than DEBOUNCE_CYCLES cycles at s produce no press.
  - A release also takes DEBOUNCE_CYCLES stable cycles to be accepted.
- Latency: if the press is first sampled at edge k, diff updates at edge k+DEBOUNCE_CYCLES+3, and diff_changed is high during the cycle that follows that edge.
- State machine, states EASY (001), MEDIUM (010), HARD (100):
  - up press: EASY→MEDIUM, MEDIUM→HARD. HARD saturates (no wrap).
  - down press: HARD→MEDIUM, MEDIUM→EASY. EASY saturates.
  - Saturated press: diff unchanged, diff_changed stays 0.
  - up and down presses in the same cycle: both ignored.
  - Press pulse while lock = 1: discarded, never queued. Releasing lock later applies nothing.
  - Debouncing keeps running while locked. A button held through lock de-assertion does not re-trigger; a fresh release and press is needed.
  - lock changing on the same cycle as a press: the value of lock sampled on that edge decides.
- Illegal diff encoding (not one-hot, e.g. from an SEU): next edge forces EASY and pulses diff_changed.
- Reset mid-debounce or mid-pulse: all state clears immediately; no spurious press after rst falls, even if a button is held (db starts released, so a held button is accepted after DEBOUNCE_CYCLES and produces one press).
- diff is driven straight from flops; no combinational path from inputs to outputs.

Decomposition:
- Shared defines header: DIFF_EASY = 3'b001, DIFF_MEDIUM = 3'b010, DIFF_HARD = 3'b100, DIFF_W = 3. The same header is used by the display stage and the game-timing logic.
- One sub-module, key_debounce: synchroniser + counter + press pulse, parameterised by DEBOUNCE_CYCLES. It is instantiated twice (up, down).
- The FSM lives in difficulty_select.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset release, no presses for 50 cycles → diff = 001 throughout, diff_changed never high.
- key_up_n held low from edge 10 onward → diff = 010 at edge 17, diff_changed high exactly one cycle, then no further change while held.
- Three clean up presses (each held 10 cycles, released 10 cycles), then one more up → diff 010, 100, 100, 100. Only two diff_changed pulses; same check mirrored with down presses back to 001.
- key_up_n low for 3 cycles, then high; repeat a 1-cycle-off chatter pattern → diff stays 001, no pulse.
- lock = 1, clean up press, lock = 0 while still held, then release → diff stays 001. A subsequent fresh press → 010.
- Both keys pressed on the same cycle → no change. Force diff to 011 via testbench → 001 on the next edge with one diff_changed pulse. Assert rst mid-debounce → diff = 001 immediately, no pulse after release.
